board_uart_tx: RTL and testbench
================================

BOARD_UART_TX -- requirements
Module: board_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, is the number of clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 Port clk  input  1  is the single system clock; all state updates occur on its rising edge.
REQ-003 Port rst  input  1  is the asynchronous, active-low reset.
REQ-004 Port start  input  1  requests one board dump; it is a level sampled on each rising clk edge.
REQ-005 Port board_flat  input  336  carries 16 tiles of 21 bits each: tile rc = row*4+col occupies board_flat[rc*21 +: 21].
REQ-006 Port tx  output  1  is the UART serial line, 8N1, idle high.
REQ-007 Port busy  output  1  is high while a dump is in progress.
REQ-008 Port done  output  1  is a one-cycle pulse marking completion of a dump.

Function
REQ-009 The block SHALL use an FSM with states IDLE, START_BIT, DATA_BITS and STOP_BIT, plus a baud counter, a bit index (0-7) and a byte index (0-23).
REQ-010 In IDLE, start=1 at an edge SHALL snapshot board_flat into internal registers, set busy=1 and enter START_BIT at that same edge.
REQ-011 start SHALL be ignored whenever the FSM is not in IDLE.
REQ-012 Changes on board_flat after the snapshot SHALL NOT affect the transmitted bytes.
REQ-013 The dump SHALL be 24 bytes, sent in order:
- row 0: tiles col 0..3, then 0x0D, then 0x0A;
- rows 1, 2 and 3 follow in the same format.
REQ-014 Tile encoding SHALL be:
- value 0 -> '0' (0x30);
- value 2^k with 1<=k<=9 -> ASCII '1'..'9';
- value 2^k with 10<=k<=15 -> 'A'..'F' (0x41..0x46);
- any other value (1, non-power-of-two, or >=2^16) -> '?' (0x3F).
REQ-015 Each byte SHALL be framed as a start bit (0), 8 data bits LSB first, and a stop bit (1); each bit is held on tx for exactly CLKS_PER_BIT cycles.
REQ-016 Bytes SHALL be sent back-to-back: the start bit of byte n+1 begins on the cycle after the last stop-bit cycle of byte n.
REQ-017 The tx falling edge of the first start bit SHALL appear in the cycle after start is accepted.
REQ-018 One dump SHALL last exactly 240*CLKS_PER_BIT cycles, measured from the first start-bit cycle to the last stop-bit cycle inclusive.
REQ-019 At the edge ending the final stop bit, the block SHALL return to IDLE, drive busy=0 and pulse done=1 for one cycle.
REQ-020 start high during the done cycle SHALL be accepted at the following edge, beginning a new dump with a new snapshot.
REQ-021 tx, busy and done SHALL be registered outputs with no combinational path from any input.

Reset
REQ-022 rst=0 SHALL immediately, without waiting for a clock edge, force: FSM=IDLE, tx=1, busy=0, done=0, all counters 0.
REQ-023 Reset asserted mid-byte SHALL abort the dump with no further bits sent; after release, the block waits in IDLE for a new start.
REQ-024 Snapshot registers need no reset value.

Verification (CLKS_PER_BIT=4)
REQ-025 All-zero board, one start pulse -> bytes "0000\r\n" x4 (30 30 30 30 0D 0A, repeated); busy high 960 cycles; single done pulse.
REQ-026 Tile (0,0)=2, tile (3,3)=2048, tile (1,2)=6, all others 0 -> byte 0=0x31, byte 8=0x3F, byte 21=0x42, all other tile bytes 0x30.
REQ-027 start held high for the whole dump, board changed mid-dump -> output matches the original snapshot; a second dump starts one cycle after done and reflects the new board.
REQ-028 rst driven low during bit 3 of byte 5 -> tx=1 and busy=0 within the same cycle; no done pulse; after release, a start yields a complete correct dump.
REQ-029 Bit timing check -> every bit lasts 4 cycles, LSB first, stop bit =1; no idle gap between bytes; byte 0 start bit begins the cycle after start is accepted.

Source files
------------

// File: rtl/board_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : board_uart_tx
// Brief    : Dumps a 4x4 board of tile values as 24 ASCII bytes over 8N1 UART.
// Revision : 1.0
// ============================================================================
module board_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [335:0] board_flat,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int                  c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]          c_LAST_BYTE = 5'd23;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_BAUD_W-1:0] r_baud, w_baud_nxt;
    logic [2:0]          r_bit_idx, w_bit_idx_nxt, w_bit_idx_inc;
    logic [4:0]          r_byte_idx, w_byte_idx_nxt;
    logic                r_tx, w_tx_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                w_accept;
    logic [335:0]        r_board;

    logic [1:0]          w_row;
    logic [2:0]          w_pos;
    logic [3:0]          w_tile_idx;
    logic [20:0]         w_tile;
    logic [7:0]          w_code;
    logic [7:0]          w_byte;

    // Byte n of the dump: row n/6, position n%6 (four tiles, then CR, LF).
    always_comb begin
        w_row      = 2'(r_byte_idx / 5'd6);
        w_pos      = 3'(r_byte_idx % 5'd6);
        w_tile_idx = {w_row, w_pos[1:0]};
        w_tile     = r_board[w_tile_idx*21 +: 21];

        w_code = 8'h3F;
        if (w_tile == 21'd0) begin
            w_code = 8'h30;
        end else begin
            for (int k = 1; k < 16; k++) begin
                if (w_tile == (21'd1 << k)) begin
                    w_code = (k < 10) ? 8'(8'h30 + k) : 8'(8'h37 + k);
                end
            end
        end

        if (!w_pos[2]) begin
            w_byte = w_code;
        end else if (w_pos[0]) begin
            w_byte = 8'h0A;
        end else begin
            w_byte = 8'h0D;
        end
    end

    assign w_bit_idx_inc = r_bit_idx + 3'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_baud_nxt     = r_baud;
        w_bit_idx_nxt  = r_bit_idx;
        w_byte_idx_nxt = r_byte_idx;
        w_tx_nxt       = r_tx;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_accept       = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept       = 1'b1;
                    w_state_nxt    = START_BIT;
                    w_tx_nxt       = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_baud_nxt     = '0;
                    w_bit_idx_nxt  = 3'd0;
                    w_byte_idx_nxt = 5'd0;
                end
            end
            START_BIT: begin
                if (r_baud == c_BAUD_LAST) begin
                    w_baud_nxt    = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = DATA_BITS;
                    w_tx_nxt      = w_byte[0];
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            DATA_BITS: begin
                if (r_baud == c_BAUD_LAST) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP_BIT;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_idx_nxt = w_bit_idx_inc;
                        w_tx_nxt      = w_byte[w_bit_idx_inc];
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            STOP_BIT: begin
                if (r_baud == c_BAUD_LAST) begin
                    w_baud_nxt = '0;
                    if (r_byte_idx == c_LAST_BYTE) begin
                        w_state_nxt    = IDLE;
                        w_tx_nxt       = 1'b1;
                        w_busy_nxt     = 1'b0;
                        w_done_nxt     = 1'b1;
                        w_byte_idx_nxt = 5'd0;
                    end else begin
                        w_byte_idx_nxt = r_byte_idx + 5'd1;
                        w_state_nxt    = START_BIT;
                        w_tx_nxt       = 1'b0;
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 5'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud     <= w_baud_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Snapshot has no reset; it is only read while a dump is in flight.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_board <= board_flat;
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_board_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_board_uart_tx
// Brief    : Scoreboard bench for board_uart_tx: queued expected bytes vs a
//            cycle-exact UART frame monitor. Revision : 1.0
// ============================================================================
module tb_board_uart_tx;

    localparam int CPB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [335:0] board_flat;
    logic         tx;
    logic         busy;
    logic         done;

    int           total = 0;
    int           bad   = 0;
    logic [7:0]   sb[$];

    board_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .board_flat (board_flat),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Tile text: zero -> '0', a single power of two 2..2^15 -> its exponent as a hex digit.
    function automatic logic [7:0] enc(input logic [20:0] v);
        string digits = "0123456789ABCDEF";
        if (v == 21'd0) return 8'h30;
        if ($countones(v) == 1 && v > 21'd1 && v < 21'h10000) return digits[$clog2(v)];
        return 8'h3F;
    endfunction

    task automatic push_dump(input logic [335:0] b);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) sb.push_back(enc(b[(r*4+c)*21 +: 21]));
            sb.push_back(8'h0D);
            sb.push_back(8'h0A);
        end
    endtask

    // Expected tx level for each of the 10*CPB cycles of one frame.
    function automatic logic [39:0] frame(input logic [7:0] d);
        logic [39:0] f;
        for (int i = 0; i < 10*CPB; i++) begin
            int b = i / CPB;
            f[i] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
        end
        return f;
    endfunction

    function automatic logic [335:0] rand_board();
        logic [335:0] b;
        logic [20:0]  v;
        for (int t = 0; t < 16; t++) begin
            case ($urandom_range(0, 3))
                0:       v = 21'd0;
                1:       v = 21'(1) << $urandom_range(0, 20);
                2:       v = 21'($urandom);
                default: v = 21'(1) << $urandom_range(1, 15);
            endcase
            b[t*21 +: 21] = v;
        end
        return b;
    endfunction

    // Monitor: samples tx on falling edges, captures whole frames, pops and compares.
    initial begin
        bit          pending;
        bit          aborted;
        int          dump_pos;
        logic [39:0] s;
        logic [7:0]  exp_b;
        pending  = 1'b0;
        dump_pos = 0;
        forever begin
            if (!pending) @(negedge clk);
            pending = 1'b0;
            if (rst !== 1'b1) begin
                dump_pos = 0;
            end else if (tx === 1'b0) begin
                s       = '0;
                s[0]    = tx;
                aborted = 1'b0;
                for (int i = 1; i < 10*CPB; i++) begin
                    @(negedge clk);
                    if (rst !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[i] = tx;
                end
                if (aborted) begin
                    dump_pos = 0;
                end else if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got waveform %0h, expected no frame", s);
                end else begin
                    exp_b = sb.pop_front();
                    check("frame", 64'(s), 64'(frame(exp_b)));
                    dump_pos = (dump_pos + 1) % 24;
                    if (dump_pos != 0) begin
                        @(negedge clk);
                        check("gap", 64'(tx), 64'd0);
                        pending = 1'b1;
                    end
                end
            end
        end
    end

    task automatic accept(input logic [335:0] b);
        @(posedge clk);
        #1;
        board_flat = b;
        start      = 1'b1;
        push_dump(b);
        @(posedge clk);
        #1;
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_tx", 64'(tx), 64'd0);
    endtask

    // Counts busy cycles until done; optionally swaps the board mid-dump.
    task automatic wait_done(input int change_at, input logic [335:0] nbd, input int nb0);
        int nb;
        bit ok;
        nb = nb0;
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (i == change_at) begin
                board_flat = nbd;
                push_dump(nbd);
            end
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (busy === 1'b1) nb++;
        end
        check("done_seen", 64'(ok), 64'd1);
        check("busy_len", 64'(nb), 64'd960);
        check("busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("done_width", 64'(done), 64'd0);
    endtask

    initial begin
        logic [335:0] b;
        logic [335:0] b2;
        bit           flag;

        rst        = 1'b1;
        start      = 1'b0;
        board_flat = '0;
        #2;
        rst = 1'b0;
        #1;
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // All-zero board
        accept('0);
        start = 1'b0;
        wait_done(-1, '0, 0);

        // Directed tiles: (0,0)=2, (3,3)=2048, (1,2)=6
        b = '0;
        b[0*21 +: 21]  = 21'd2;
        b[15*21 +: 21] = 21'd2048;
        b[6*21 +: 21]  = 21'd6;
        accept(b);
        start = 1'b0;
        wait_done(-1, '0, 0);

        // start held through the dump, board changed mid-dump, immediate re-dump
        b  = rand_board();
        b2 = rand_board();
        accept(b);
        wait_done(300, b2, 0);
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_tx", 64'(tx), 64'd0);
        start = 1'b0;
        wait_done(-1, '0, 1);

        for (int n = 0; n < 3; n++) begin
            accept(rand_board());
            start = 1'b0;
            wait_done(-1, '0, 0);
        end

        // Reset during data bit 3 of byte 5
        accept(rand_board());
        start = 1'b0;
        repeat (217) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_async_tx", 64'(tx), 64'd1);
        check("rst_async_busy", 64'(busy), 64'd0);
        check("abort_remaining", 64'(sb.size()), 64'd19);
        flag = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) flag = 1'b1;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) flag = 1'b1;
        end
        check("quiet_after_rst", 64'(flag), 64'd0);
        accept(rand_board());
        start = 1'b0;
        wait_done(-1, '0, 0);

        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
